wb_writeback_arbiter: RTL and testbench

- Drives the single write port of the ID-stage register file: Write_Register_WB, Write_Data_WB and RegWrite_WB.
- Merges two result sources:
  - the in-order MEM/WB pipeline, which carries ALU results or load data;
  - an out-of-order multi-cycle multiply/divide unit (MDU), whose results are held in a small FIFO.
- Drains MDU results into idle pipeline write slots.
- Stalls the pipeline only when the FIFO is full.

---
 rtl/wb_pkg.sv | 19 +
 rtl/wb_writeback_arbiter_fifo.sv | 70 +++++++
 rtl/wb_writeback_arbiter.sv | 115 +++++++++++
 tb/tb_wb_writeback_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and widths for the writeback arbiter and its MDU result FIFO.
package wb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PIPE = 2'd1,
        SRC_MDU  = 2'd2
    } wb_src_e;

    // "reg" is a reserved word, so the register index field is reg_addr.
    typedef struct packed {
        logic [ADDR_W-1:0] reg_addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_writeback_arbiter_fifo.sv
// wb_result_fifo: strict-order result queue with same-cycle read/write.
// Full and empty are told apart by the occupancy count, not by the pointers.
module wb_result_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   wr_en_i,
    input  wb_entry_t              wr_entry_i,
    input  logic                   rd_en_i,
    output wb_entry_t              head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_ok_s, rd_ok_s;

    // Qualify requests against occupancy and compute next pointers/count.
    always_comb begin
        wr_ok_s  = wr_en_i && (count_q < CNT_W'(DEPTH));
        rd_ok_s  = rd_en_i && (count_q != {CNT_W{1'b0}});
        wr_ptr_d = wr_ok_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = rd_ok_s ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        if (wr_ok_s && !rd_ok_s) begin
            count_d = count_q + CNT_W'(1);
        end else if (!wr_ok_s && rd_ok_s) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, cleared on reset so discarded results never reappear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{reg_addr: {ADDR_W{1'b0}}, data: {DATA_W{1'b0}}};
            end
        end else if (wr_ok_s) begin
            mem_q[wr_ptr_q] <= wr_entry_i;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/wb_writeback_arbiter.sv
// Register-file write port arbiter: MEM/WB pipeline results take the slot,
// MDU results are queued and drained into idle slots or forced in when full.
module wb_writeback_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   RegWrite_MEM,
    input  logic                   MemtoReg_MEM,
    input  logic [ADDR_W-1:0]      Write_Register_MEM,
    input  logic [DATA_W-1:0]      ALU_Result_MEM,
    input  logic [DATA_W-1:0]      Read_Data_MEM,
    input  logic                   MDU_Valid,
    input  logic [ADDR_W-1:0]      MDU_Register,
    input  logic [DATA_W-1:0]      MDU_Data,
    output logic                   MDU_Ready,
    output logic                   Pipe_Stall,
    output logic [ADDR_W-1:0]      Write_Register_WB,
    output logic [DATA_W-1:0]      Write_Data_WB,
    output logic                   RegWrite_WB,
    output logic [$clog2(DEPTH):0] Fifo_Count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0]  fifo_count_s;
    wb_entry_t         fifo_head_s;
    wb_entry_t         mdu_entry_s;
    logic              fifo_full_s, fifo_empty_s;
    logic              pipe_req_s, enq_s, deq_s;
    wb_src_e           src_s;
    logic              wb_we_q, wb_we_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;

    assign fifo_full_s  = (fifo_count_s == CNT_W'(DEPTH));
    assign fifo_empty_s = (fifo_count_s == {CNT_W{1'b0}});
    assign pipe_req_s   = RegWrite_MEM && (Write_Register_MEM != {ADDR_W{1'b0}});
    assign MDU_Ready    = !fifo_full_s;
    // Register-0 results finish the handshake but are dropped here.
    assign enq_s        = MDU_Valid && MDU_Ready && (MDU_Register != {ADDR_W{1'b0}});
    assign mdu_entry_s  = '{reg_addr: MDU_Register, data: MDU_Data};

    wb_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (Clk),
        .rst_n_i    (Reset_n),
        .wr_en_i    (enq_s),
        .wr_entry_i (mdu_entry_s),
        .rd_en_i    (deq_s),
        .head_o     (fifo_head_s),
        .count_o    (fifo_count_s)
    );

    // Pick the write-port winner; a full FIFO pre-empts the pipeline once.
    always_comb begin
        src_s      = SRC_NONE;
        Pipe_Stall = 1'b0;
        if (fifo_full_s && pipe_req_s) begin
            src_s      = SRC_MDU;
            Pipe_Stall = 1'b1;
        end else if (pipe_req_s) begin
            src_s = SRC_PIPE;
        end else if (!fifo_empty_s) begin
            src_s = SRC_MDU;
        end else begin
            src_s = SRC_NONE;
        end
        deq_s = (src_s == SRC_MDU);
    end

    // Next value of the write-port register; address/data hold when idle.
    always_comb begin
        wb_we_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        case (src_s)
            SRC_PIPE: begin
                wb_we_d   = 1'b1;
                wb_addr_d = Write_Register_MEM;
                wb_data_d = MemtoReg_MEM ? Read_Data_MEM : ALU_Result_MEM;
            end
            SRC_MDU: begin
                wb_we_d   = 1'b1;
                wb_addr_d = fifo_head_s.reg_addr;
                wb_data_d = fifo_head_s.data;
            end
            default: begin
                wb_we_d = 1'b0;
            end
        endcase
    end

    // Write-port output register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wb_we_q   <= 1'b0;
            wb_addr_q <= {ADDR_W{1'b0}};
            wb_data_q <= {DATA_W{1'b0}};
        end else begin
            wb_we_q   <= wb_we_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign RegWrite_WB       = wb_we_q;
    assign Write_Register_WB = wb_addr_q;
    assign Write_Data_WB     = wb_data_q;
    assign Fifo_Count        = fifo_count_s;

endmodule

// File: tb/tb_wb_writeback_arbiter.sv
// Directed bench for wb_writeback_arbiter (DEPTH=2) with hand-computed expectations.
module tb_wb_writeback_arbiter;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        RegWrite_MEM, MemtoReg_MEM;
    logic [4:0]  Write_Register_MEM;
    logic [31:0] ALU_Result_MEM, Read_Data_MEM;
    logic        MDU_Valid;
    logic [4:0]  MDU_Register;
    logic [31:0] MDU_Data;
    logic        MDU_Ready, Pipe_Stall, RegWrite_WB;
    logic [4:0]  Write_Register_WB;
    logic [31:0] Write_Data_WB;
    logic [1:0]  Fifo_Count;

    int vectors = 0;
    int miscompares = 0;

    wb_writeback_arbiter #(.DEPTH(2)) dut (
        .Clk                (Clk),
        .Reset_n            (Reset_n),
        .RegWrite_MEM       (RegWrite_MEM),
        .MemtoReg_MEM       (MemtoReg_MEM),
        .Write_Register_MEM (Write_Register_MEM),
        .ALU_Result_MEM     (ALU_Result_MEM),
        .Read_Data_MEM      (Read_Data_MEM),
        .MDU_Valid          (MDU_Valid),
        .MDU_Register       (MDU_Register),
        .MDU_Data           (MDU_Data),
        .MDU_Ready          (MDU_Ready),
        .Pipe_Stall         (Pipe_Stall),
        .Write_Register_WB  (Write_Register_WB),
        .Write_Data_WB      (Write_Data_WB),
        .RegWrite_WB        (RegWrite_WB),
        .Fifo_Count         (Fifo_Count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_wb(input string tag, input logic we, input logic [4:0] addr,
                          input logic [31:0] data);
        chk({tag, "_we"},   32'(RegWrite_WB),       32'(we));
        chk({tag, "_addr"}, 32'(Write_Register_WB), 32'(addr));
        chk({tag, "_data"}, Write_Data_WB,          data);
    endtask

    initial begin
        Reset_n = 1'b0;
        RegWrite_MEM = 1'b0; MemtoReg_MEM = 1'b0; Write_Register_MEM = 5'd0;
        ALU_Result_MEM = 32'd0; Read_Data_MEM = 32'd0;
        MDU_Valid = 1'b0; MDU_Register = 5'd0; MDU_Data = 32'd0;

        // Reset state
        #12;
        chk_wb("rst", 1'b0, 5'd0, 32'h0);
        chk("rst_count", 32'(Fifo_Count), 32'd0);
        Reset_n = 1'b1;
        #1;
        chk("rst_ready", 32'(MDU_Ready), 32'd1);
        chk("rst_stall", 32'(Pipe_Stall), 32'd0);

        // Pipeline only: load data, then a register-0 write, then ALU data
        tick();
        RegWrite_MEM = 1'b1; Write_Register_MEM = 5'd5; MemtoReg_MEM = 1'b1;
        Read_Data_MEM = 32'hDEADBEEF; ALU_Result_MEM = 32'h55;
        tick();
        chk_wb("pipe_load", 1'b1, 5'd5, 32'hDEADBEEF);
        Write_Register_MEM = 5'd0;
        tick();
        chk_wb("pipe_r0", 1'b0, 5'd5, 32'hDEADBEEF);
        Write_Register_MEM = 5'd6; MemtoReg_MEM = 1'b0; ALU_Result_MEM = 32'hA5A5A5A5;
        tick();
        chk_wb("pipe_alu", 1'b1, 5'd6, 32'hA5A5A5A5);
        RegWrite_MEM = 1'b0;
        tick();
        chk("pipe_idle_we", 32'(RegWrite_WB), 32'd0);

        // MDU into idle slot: offered after edge N, transferred at N+1, written at N+2
        MDU_Valid = 1'b1; MDU_Register = 5'd9; MDU_Data = 32'h12345678;
        #1;
        chk("mdu_ready", 32'(MDU_Ready), 32'd1);
        tick();
        chk("mdu_count1", 32'(Fifo_Count), 32'd1);
        chk("mdu_nowrite_yet", 32'(RegWrite_WB), 32'd0);
        MDU_Valid = 1'b0;
        tick();
        chk_wb("mdu_write", 1'b1, 5'd9, 32'h12345678);
        chk("mdu_count0", 32'(Fifo_Count), 32'd0);

        // FIFO full with continuous pipeline requests
        RegWrite_MEM = 1'b1; Write_Register_MEM = 5'd7; ALU_Result_MEM = 32'h11;
        MDU_Valid = 1'b1; MDU_Register = 5'd3; MDU_Data = 32'h33;
        tick();
        chk_wb("full_e1", 1'b1, 5'd7, 32'h11);
        chk("full_e1_count", 32'(Fifo_Count), 32'd1);
        MDU_Register = 5'd4; MDU_Data = 32'h44;
        #1;
        chk("full_e1_stall", 32'(Pipe_Stall), 32'd0);
        tick();
        chk_wb("full_e2", 1'b1, 5'd7, 32'h11);
        chk("full_e2_count", 32'(Fifo_Count), 32'd2);
        MDU_Register = 5'd8; MDU_Data = 32'h88;
        #1;
        chk("full_ready0", 32'(MDU_Ready), 32'd0);
        chk("full_stall1", 32'(Pipe_Stall), 32'd1);
        tick();
        chk_wb("full_head3", 1'b1, 5'd3, 32'h33);
        chk("full_no_passthru", 32'(Fifo_Count), 32'd1);
        chk("full_stall_off", 32'(Pipe_Stall), 32'd0);
        chk("full_ready1", 32'(MDU_Ready), 32'd1);
        MDU_Valid = 1'b0;
        tick();
        chk_wb("full_pipe7", 1'b1, 5'd7, 32'h11);
        chk("full_e4_count", 32'(Fifo_Count), 32'd1);
        RegWrite_MEM = 1'b0;
        tick();
        chk_wb("full_drain4", 1'b1, 5'd4, 32'h44);
        chk("full_e5_count", 32'(Fifo_Count), 32'd0);
        tick();
        chk("full_idle_we", 32'(RegWrite_WB), 32'd0);

        // Back-to-back MDU results: simultaneous enqueue/dequeue holds count at 1
        for (int i = 1; i <= 6; i++) begin
            MDU_Valid = 1'b1; MDU_Register = 5'(9 + i); MDU_Data = 32'(i);
            tick();
            chk($sformatf("b2b_count_%0d", i), 32'(Fifo_Count), 32'd1);
            if (i > 1) begin
                chk_wb($sformatf("b2b_out_%0d", i - 1), 1'b1, 5'(8 + i), 32'(i - 1));
            end else begin
                chk("b2b_first_we", 32'(RegWrite_WB), 32'd0);
            end
        end
        MDU_Valid = 1'b0;
        tick();
        chk_wb("b2b_out_6", 1'b1, 5'd15, 32'd6);
        chk("b2b_count_end", 32'(Fifo_Count), 32'd0);

        // MDU result to register 0 is accepted and dropped
        MDU_Valid = 1'b1; MDU_Register = 5'd0; MDU_Data = 32'hBAD;
        #1;
        chk("r0_ready", 32'(MDU_Ready), 32'd1);
        tick();
        chk("r0_count", 32'(Fifo_Count), 32'd0);
        MDU_Valid = 1'b0;
        tick();
        chk("r0_no_write", 32'(RegWrite_WB), 32'd0);
        chk("r0_count2", 32'(Fifo_Count), 32'd0);

        // Reset mid-operation with two queued entries
        RegWrite_MEM = 1'b1; Write_Register_MEM = 5'd7; ALU_Result_MEM = 32'h11;
        MDU_Valid = 1'b1; MDU_Register = 5'd20; MDU_Data = 32'h20;
        tick();
        MDU_Register = 5'd21; MDU_Data = 32'h21;
        tick();
        chk("mid_count2", 32'(Fifo_Count), 32'd2);
        MDU_Valid = 1'b0; RegWrite_MEM = 1'b0;
        #2;
        Reset_n = 1'b0;
        #1;
        chk_wb("mid_rst", 1'b0, 5'd0, 32'h0);
        chk("mid_rst_count", 32'(Fifo_Count), 32'd0);
        #2;
        Reset_n = 1'b1;
        #1;
        chk("mid_ready", 32'(MDU_Ready), 32'd1);
        tick();
        chk("mid_no_write1", 32'(RegWrite_WB), 32'd0);
        tick();
        chk("mid_no_write2", 32'(RegWrite_WB), 32'd0);
        chk("mid_count_end", 32'(Fifo_Count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
